uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per frame; legal range 5..9.
REQ-002 SHALL have parameter PRESC_WIDTH, default 6, width of the Prescale input.
REQ-003 SHALL have port CLK, input, 1, single clock; all state on its rising edge.
REQ-004 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port P_DATA, input, DATA_WIDTH, payload word to transmit.
REQ-006 SHALL have port Data_Valid, input, 1, offers P_DATA for acceptance.
REQ-007 SHALL have port ready, output, 1, holding buffer empty; a word is accepted when Data_Valid and ready are both high at a rising edge.
REQ-008 SHALL have port parity_enable, input, 1, 1 inserts a parity bit.
REQ-009 SHALL have port parity_type, input, 1, 0 even, 1 odd.
REQ-010 SHALL have port stop_bits, input, 1, 0 one stop bit, 1 two stop bits.
REQ-011 SHALL have port Prescale, input, PRESC_WIDTH, CLK cycles per bit; value 0 treated as 1.
REQ-012 SHALL have port TX_OUT, output, 1, registered serial line, idle high.
REQ-013 SHALL have port busy, output, 1, high while a frame is on the line.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse at frame completion.

Function
REQ-015 SHALL contain a one-word holding buffer: accepted word is stored with its parity_enable, parity_type and stop_bits values, and buffer is marked full.
REQ-016 SHALL drive ready = NOT buffer_full, from a registered flag; Data_Valid while ready low SHALL be ignored and the word dropped.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-018 In IDLE with buffer full, the next edge SHALL move the word into the shift register, clear buffer_full, enter START and drive TX_OUT low. Start bit is visible one edge after acceptance.
REQ-019 Every bit SHALL be held for exactly max(Prescale,1) CLK cycles, counted by an internal bit-period counter. Prescale is sampled at frame load and held for the whole frame.
REQ-020 Transitions SHALL occur only at bit-period end: START->DATA. DATA->DATA until DATA_WIDTH bits are sent, LSB first. Last data bit -> PARITY if parity_enable, else STOP1. PARITY->STOP1. STOP1->STOP2 if stop_bits, else end of frame. STOP2 -> end of frame.
REQ-021 Parity bit SHALL be the XOR of the DATA_WIDTH payload bits when even, and its inverse when odd, using the configuration latched with that word.
REQ-022 TX_OUT SHALL be 1 in STOP1, STOP2 and IDLE.
REQ-023 At end of frame, frame_done SHALL pulse for one cycle.
REQ-024 At end of frame with buffer full, START of the next word SHALL begin on that same edge, with no idle cycle. Otherwise the FSM SHALL enter IDLE.
REQ-025 busy SHALL be high from the first START cycle through the last stop-bit cycle, and low in IDLE. It SHALL stay continuously high across back-to-back frames.
REQ-026 A word may be accepted in any state while ready is high, including during an active frame (double buffering).
REQ-027 If a buffer transfer to the shift register and Data_Valid occur on the same edge, Data_Valid SHALL be ignored because ready was low.
REQ-028 Configuration input changes mid-frame SHALL NOT affect the frame in flight.

Reset
REQ-029 On RST low, asynchronously: TX_OUT=1, busy=0, frame_done=0, buffer_full=0 (ready=1), FSM=IDLE, counters=0. A frame in progress SHALL be aborted without further output.
REQ-030 After RST is released, the first valid acceptance SHALL behave as from IDLE.

Verification
REQ-031 DATA_WIDTH=8, Prescale=4, 0xA5, parity even, 1 stop -> TX_OUT bits 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles; busy high 44 cycles; one frame_done pulse.
REQ-032 0xA5, odd parity, 2 stop, Prescale=1 -> parity bit 1; 12-cycle frame; STOP2 high.
REQ-033 Two words 0x0F, 0xF0 offered back-to-back, no parity, Prescale=2 -> second is accepted during the first frame; its start bit immediately follows the first stop bit; busy never drops; 2 frame_done pulses.
REQ-034 Third word offered while buffer full -> ready=0, word dropped; only two frames are transmitted.
REQ-035 RST asserted during DATA of 0x55 -> TX_OUT=1, busy=0, ready=1 immediately; no frame_done; a subsequent 0x3C transmits correctly.
REQ-036 Prescale=0 with 0x81 -> identical to the Prescale=1 waveform.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a one-word
// holding buffer, optional parity and one or two stop bits.
module uart_tx_cfg #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  output logic                   ready,
  input  logic                   parity_enable,
  input  logic                   parity_type,
  input  logic                   stop_bits,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT =
    BW'(DATA_WIDTH - 1);
  localparam logic [PRESC_WIDTH-1:0] ONE =
    PRESC_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t                  r_state;
  logic [PRESC_WIDTH-1:0]  r_cnt;
  logic [PRESC_WIDTH-1:0]  r_presc;
  logic [BW-1:0]           r_bitcnt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_par;
  logic                    r_pe;
  logic                    r_sb;
  logic                    r_tx;
  logic                    r_busy;
  logic                    r_done;

  logic                    r_full;
  logic [DATA_WIDTH-1:0]   r_buf;
  logic                    r_buf_pe;
  logic                    r_buf_pt;
  logic                    r_buf_sb;

  logic                    w_accept;
  logic                    w_bit_end;
  logic                    w_frame_end;
  logic                    w_load;
  logic [PRESC_WIDTH-1:0]  w_presc;
  logic                    w_par;

  assign w_accept  = Data_Valid & ~r_full;
  assign w_bit_end = (r_cnt == r_presc - ONE);
  assign w_frame_end = w_bit_end &
    (((r_state == STOP1) & ~r_sb) |
     (r_state == STOP2));
  assign w_load = r_full &
    ((r_state == IDLE) | w_frame_end);
  assign w_presc =
    (Prescale == '0) ? ONE : Prescale;
  assign w_par = (^r_buf) ^ r_buf_pt;

  assign ready      = ~r_full;
  assign TX_OUT     = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

  // Holding buffer: filled on accept, emptied on load.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_full   <= 1'b0;
      r_buf    <= '0;
      r_buf_pe <= 1'b0;
      r_buf_pt <= 1'b0;
      r_buf_sb <= 1'b0;
    end else if (w_load) begin
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_full   <= 1'b1;
      r_buf    <= P_DATA;
      r_buf_pe <= parity_enable;
      r_buf_pt <= parity_type;
      r_buf_sb <= stop_bits;
    end
  end

  // Frame FSM with registered line, busy and done.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_presc  <= ONE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_pe     <= 1'b0;
      r_sb     <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_load) begin
        r_state  <= START;
        r_tx     <= 1'b0;
        r_busy   <= 1'b1;
        r_cnt    <= '0;
        r_presc  <= w_presc;
        r_shift  <= r_buf;
        r_par    <= w_par;
        r_pe     <= r_buf_pe;
        r_sb     <= r_buf_sb;
        r_bitcnt <= '0;
      end else if ((r_state == IDLE) ||
                   w_frame_end) begin
        r_state <= IDLE;
        r_tx    <= 1'b1;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else if (!w_bit_end) begin
        r_cnt <= r_cnt + ONE;
      end else begin
        r_cnt <= '0;
        unique case (r_state)
          START: begin
            r_state  <= DATA;
            r_tx     <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitcnt <= '0;
          end
          DATA: begin
            if (r_bitcnt == LAST_BIT) begin
              r_state <= r_pe ? PARITY : STOP1;
              r_tx    <= r_pe ? r_par : 1'b1;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
            end
          end
          PARITY: begin
            r_state <= STOP1;
            r_tx    <= 1'b1;
          end
          STOP1: begin
            r_state <= STOP2;
            r_tx    <= 1'b1;
          end
          default: begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
